rr_onehot_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource among NUM_REQ requesters.
- Keeps a binary grant index and drives a registered one-hot grant vector decoded from it, so one-hot select lines can feed a mux or enable bank directly.
- Supports hold-until-release ownership plus forced rotation after MAX_HOLD cycles, so no requester can starve the others.

---
 rtl/rr_onehot_arbiter_if.sv | 25 ++
 rtl/rr_onehot_arbiter.sv | 114 +++++++++++
 tb/tb_rr_onehot_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// master: requester side drives req_i; slave: arbiter drives the grant.
interface rr_onehot_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [ID_W-1:0]    gnt_id_o;
  logic               gnt_vld_o;

  modport master (
    output req_i,
    input  gnt_o,
    input  gnt_id_o,
    input  gnt_vld_o
  );

  modport slave (
    input  req_i,
    output gnt_o,
    output gnt_id_o,
    output gnt_vld_o
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter, registered one-hot + binary grant, forced rotation.
// Ports: clk, reset_n (sync, active-low), bus (req_i in; gnt_o/id/vld out).
module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  rr_onehot_arbiter_if.slave bus
);
  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [ID_W-1:0]    id_q, id_n;
  logic               vld_q, vld_n;
  logic [ID_W-1:0]    last_q, last_n;
  logic [HC_W-1:0]    hc_q, hc_n;

  logic [NUM_REQ-1:0] others;
  logic [ID_W-1:0]    win_idle;
  logic [ID_W-1:0]    win_oth;

  // First set bit of cand searching base+1 .. base, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] cand,
    input logic [ID_W-1:0]    base
  );
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] win;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, base} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ))
        sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && cand[sum[ID_W-1:0]]) begin
        win   = sum[ID_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign others   = bus.req_i & ~(NUM_REQ'(1) << id_q);
  assign win_idle = rr_pick(bus.req_i, last_q);
  assign win_oth  = rr_pick(others, id_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      gnt_q  <= '0;
      id_q   <= '0;
      vld_q  <= 1'b0;
      last_q <= LAST_INIT;
      hc_q   <= '0;
    end else begin
      state  <= state_n;
      gnt_q  <= gnt_n;
      id_q   <= id_n;
      vld_q  <= vld_n;
      last_q <= last_n;
      hc_q   <= hc_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    id_n    = id_q;
    vld_n   = vld_q;
    last_n  = last_q;
    hc_n    = hc_q;
    unique case (state)
      IDLE: begin
        if (|bus.req_i) begin
          state_n = GRANT;
          id_n    = win_idle;
          gnt_n   = NUM_REQ'(1) << win_idle;
          vld_n   = 1'b1;
          last_n  = win_idle;
          hc_n    = '0;
        end
      end
      GRANT: begin
        // Release and preempt both hand over to the next other requester.
        if (|others &&
            (!bus.req_i[id_q] || hc_q == HC_MAX)) begin
          id_n   = win_oth;
          gnt_n  = NUM_REQ'(1) << win_oth;
          last_n = win_oth;
          hc_n   = '0;
        end else if (!bus.req_i[id_q]) begin
          state_n = IDLE;
          gnt_n   = '0;
          vld_n   = 1'b0;
        end else if (hc_q != HC_MAX) begin
          hc_n = hc_q + HC_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_id_o  = id_q;
  assign bus.gnt_vld_o = vld_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter (NUM_REQ=4, MAX_HOLD=8).
// Expected grants are queued at drive time, popped after each edge.
module tb_rr_onehot_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       id_chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  // bench reference model state
  logic       m_vld;
  int         m_id, m_last, m_cnt;

  rr_onehot_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

  rr_onehot_arbiter #(
    .NUM_REQ (N),
    .ID_W    (2),
    .MAX_HOLD(MH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t exp_of(input logic [3:0] g);
    exp_t e;
    e.gnt    = g;
    e.vld    = |g;
    e.id_chk = |g;
    e.id     = 2'd0;
    for (int k = 0; k < N; k++)
      if (g[k]) e.id = 2'(k);
    return e;
  endfunction

  function automatic int m_pick(input logic [3:0] c, input int base);
    for (int k = 1; k <= N; k++)
      if (c[(base + k) % N]) return (base + k) % N;
    return 0;
  endfunction

  task automatic m_reset();
    m_vld  = 1'b0;
    m_id   = 0;
    m_last = N - 1;
    m_cnt  = 0;
  endtask

  task automatic m_step(input logic [3:0] r);
    logic [3:0] oth;
    exp_t       e;
    oth = r;
    oth[m_id] = 1'b0;
    if (!m_vld) begin
      if (r != 0) begin
        m_id = m_pick(r, m_last);
        m_vld = 1'b1;
        m_last = m_id;
        m_cnt = 0;
      end
    end else if (!r[m_id] || m_cnt == MH - 1) begin
      if (oth != 0) begin
        m_id = m_pick(oth, m_id);
        m_last = m_id;
        m_cnt = 0;
      end else if (!r[m_id]) begin
        m_vld = 1'b0;
      end
    end else begin
      m_cnt++;
    end
    e.vld = m_vld;
    e.id = 2'(m_id);
    e.gnt = m_vld ? 4'(1 << m_id) : 4'b0;
    e.id_chk = m_vld;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_i = 4'b0000;
    tick();
    tick();
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0;
    bus.req_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) reset_n = 1'b1;
      e = (i == 3) ? exp_of(4'b0001) : exp_of(4'b0000);
      e.id_chk = 1'b1;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      n_vec++;
      if (bus.gnt_o !== e.gnt || bus.gnt_vld_o !== e.vld ||
          (e.id_chk && bus.gnt_id_o !== e.id)) begin
        n_err++;
        $display("FAIL reset[%0d]: gnt=%b id=%0d vld=%b want gnt=%b id=%0d vld=%b",
                 i, bus.gnt_o, bus.gnt_id_o, bus.gnt_vld_o, e.gnt, e.id, e.vld);
      end
    end
  endtask

  task automatic test_single();
    exp_t       e;
    logic [3:0] rq[2] = '{4'b0100, 4'b0000};
    logic [3:0] eg[2] = '{4'b0100, 4'b0000};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.req_i = rq[i];
      sb.push_back(exp_of(eg[i]));
      tick();
      e = sb.pop_front();
      n_vec++;
      if (bus.gnt_o !== e.gnt || bus.gnt_vld_o !== e.vld ||
          (e.id_chk && bus.gnt_id_o !== e.id)) begin
        n_err++;
        $display("FAIL single[%0d]: gnt=%b id=%0d vld=%b want gnt=%b id=%0d vld=%b",
                 i, bus.gnt_o, bus.gnt_id_o, bus.gnt_vld_o, e.gnt, e.id, e.vld);
      end
    end
  endtask

  task automatic test_rotation();
    exp_t       e;
    logic [3:0] rq[10] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                           4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b0000};
    logic [3:0] eg[10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                           4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.req_i = rq[i];
      sb.push_back(exp_of(eg[i]));
      tick();
      e = sb.pop_front();
      n_vec++;
      if (bus.gnt_o !== e.gnt || bus.gnt_vld_o !== e.vld ||
          (e.id_chk && bus.gnt_id_o !== e.id)) begin
        n_err++;
        $display("FAIL rotation[%0d]: gnt=%b id=%0d vld=%b want gnt=%b id=%0d vld=%b",
                 i, bus.gnt_o, bus.gnt_id_o, bus.gnt_vld_o, e.gnt, e.id, e.vld);
      end
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      bus.req_i = (i < 32) ? 4'b0011 : 4'b0000;
      if (i == 32) sb.push_back(exp_of(4'b0000));
      else if (((i / MH) % 2) == 0) sb.push_back(exp_of(4'b0001));
      else sb.push_back(exp_of(4'b0010));
      tick();
      e = sb.pop_front();
      n_vec++;
      if (bus.gnt_o !== e.gnt || bus.gnt_vld_o !== e.vld ||
          (e.id_chk && bus.gnt_id_o !== e.id)) begin
        n_err++;
        $display("FAIL starvation[%0d]: gnt=%b id=%0d vld=%b want gnt=%b id=%0d vld=%b",
                 i, bus.gnt_o, bus.gnt_id_o, bus.gnt_vld_o, e.gnt, e.id, e.vld);
      end
    end
  endtask

  task automatic test_lone_hog();
    exp_t e;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      if (i < 20) begin
        bus.req_i = 4'b0001;
        sb.push_back(exp_of(4'b0001));
      end else if (i < 22) begin
        bus.req_i = 4'b1001;
        sb.push_back(exp_of(4'b1000));
      end else begin
        bus.req_i = 4'b0000;
        sb.push_back(exp_of(4'b0000));
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if (bus.gnt_o !== e.gnt || bus.gnt_vld_o !== e.vld ||
          (e.id_chk && bus.gnt_id_o !== e.id)) begin
        n_err++;
        $display("FAIL lone_hog[%0d]: gnt=%b id=%0d vld=%b want gnt=%b id=%0d vld=%b",
                 i, bus.gnt_o, bus.gnt_id_o, bus.gnt_vld_o, e.gnt, e.id, e.vld);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t       e;
    logic       rs[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] rq[4] = '{4'b0100, 4'b1111, 4'b1111, 4'b0000};
    logic [3:0] eg[4] = '{4'b0100, 4'b0000, 4'b0001, 4'b0000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      reset_n = rs[i];
      bus.req_i = rq[i];
      e = exp_of(eg[i]);
      if (!rs[i]) e.id_chk = 1'b1;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      n_vec++;
      if (bus.gnt_o !== e.gnt || bus.gnt_vld_o !== e.vld ||
          (e.id_chk && bus.gnt_id_o !== e.id)) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: gnt=%b id=%0d vld=%b want gnt=%b id=%0d vld=%b",
                 i, bus.gnt_o, bus.gnt_id_o, bus.gnt_vld_o, e.gnt, e.id, e.vld);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [3:0] r;
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      bus.req_i = r;
      m_step(r);
      tick();
      e = sb.pop_front();
      n_vec++;
      if (bus.gnt_o !== e.gnt || bus.gnt_vld_o !== e.vld ||
          (e.id_chk && bus.gnt_id_o !== e.id)) begin
        n_err++;
        $display("FAIL back_to_back[%0d] req=%b: gnt=%b id=%0d vld=%b want gnt=%b id=%0d vld=%b",
                 i, r, bus.gnt_o, bus.gnt_id_o, bus.gnt_vld_o, e.gnt, e.id, e.vld);
      end
    end
  endtask

  initial begin
    bus.req_i = 4'b0000;
    m_reset();
    test_reset();
    test_single();
    test_rotation();
    test_starvation();
    test_lone_hog();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
